lieat_wbu_arbiter: RTL

Writeback arbiter that shares the single integer register-file write port among the five execution units: com, lsu, muldiv, vpu and fpu. Each cycle it grants at most one unit using round-robin. The winner is registered into a one-stage writeback register that drives the regfile write and the wbck_ena/wbck_op pair consumed by the dispatch dependency tracker. Per-unit flushes suppress grants to flushed units.

---
 rtl/lieat_wbu_arbiter_pkg.sv | 15 +
 rtl/lieat_wbu_arbiter_if.sv | 30 +++
 rtl/lieat_general_dfflr.sv | 11 +
 rtl/lieat_wbu_rr_pick.sv | 17 +
 rtl/lieat_wbu_arbiter.sv | 68 ++++++
 5 files changed

// File: rtl/lieat_wbu_arbiter_pkg.sv
// lieat_wbu_arbiter_pkg: shared constants and types for the writeback arbiter
`ifndef REG_IDX
`define REG_IDX 5
`endif
package lieat_wbu_arbiter_pkg;
  localparam int NSRC = 5;
  localparam int WB_COM = 0;
  localparam int WB_LSU = 1;
  localparam int WB_MULDIV = 2;
  localparam int WB_VPU = 3;
  localparam int WB_FPU = 4;
  localparam int PTR_W = 3;
  localparam int PERF_W = 16;
  typedef logic [PTR_W-1:0] ptr_t;
endpackage

// File: rtl/lieat_wbu_arbiter_if.sv
// lieat_wbu_arbiter_if: unit request/flush side and writeback side of the arbiter
interface lieat_wbu_arbiter_if import lieat_wbu_arbiter_pkg::*; #(parameter int XLEN = 32) ();
  logic [NSRC-1:0] src_vld;
  logic [NSRC-1:0] src_rdy;
  logic [NSRC-1:0] src_rdwen;
  logic [NSRC*`REG_IDX-1:0] src_rd;
  logic [NSRC*XLEN-1:0] src_wdata;
  logic com_flush;
  logic lsu_flush;
  logic muldiv_flush;
  logic vpu_flush;
  logic fpu_flush;
  logic wbck_ena;
  logic [NSRC-1:0] wbck_op;
  logic wbck_rfwen;
  logic [`REG_IDX-1:0] wbck_rd;
  logic [XLEN-1:0] wbck_wdata;
  logic [2:0] perf_sel;
  logic [PERF_W-1:0] perf_cnt;
  modport master (
    output src_vld, src_rdwen, src_rd, src_wdata,
    output com_flush, lsu_flush, muldiv_flush, vpu_flush, fpu_flush, perf_sel,
    input src_rdy, wbck_ena, wbck_op, wbck_rfwen, wbck_rd, wbck_wdata, perf_cnt
  );
  modport slave (
    input src_vld, src_rdwen, src_rd, src_wdata,
    input com_flush, lsu_flush, muldiv_flush, vpu_flush, fpu_flush, perf_sel,
    output src_rdy, wbck_ena, wbck_op, wbck_rfwen, wbck_rd, wbck_wdata, perf_cnt
  );
endinterface

// File: rtl/lieat_general_dfflr.sv
// lieat_general_dfflr: load-enable flop with synchronous active-high reset
module lieat_general_dfflr #(parameter int DW = 1) (
  input  logic          clk,
  input  logic          rst,
  input  logic          lden,
  input  logic [DW-1:0] dnxt,
  output logic [DW-1:0] qout
);
  always_ff @(posedge clk)
    qout <= rst ? '0 : lden ? dnxt : qout;
endmodule

// File: rtl/lieat_wbu_rr_pick.sv
// lieat_wbu_rr_pick: one-hot round-robin pick, search ascending from ptr modulo NSRC
module lieat_wbu_rr_pick import lieat_wbu_arbiter_pkg::*; (
  input  logic [NSRC-1:0] req,
  input  ptr_t            ptr,
  output logic [NSRC-1:0] grant
);
  ptr_t idx;
  // Walk offsets from farthest to nearest so the nearest requester is written last
  always_comb begin
    grant = '0;
    idx = '0;
    for (int k = NSRC - 1; k >= 0; k--) begin
      idx = PTR_W'((int'(ptr) + k) % NSRC);
      grant = req[idx] ? NSRC'(1) << idx : grant;
    end
  end
endmodule

// File: rtl/lieat_wbu_arbiter.sv
// lieat_wbu_arbiter: round-robin regfile writeback arbiter; LIEAT_WBU_PERF_EN adds per-unit stall counters
module lieat_wbu_arbiter import lieat_wbu_arbiter_pkg::*; #(parameter int XLEN = 32) (
  input logic clock,
  input logic reset,
  lieat_wbu_arbiter_if.slave bus
);
  logic [NSRC-1:0] flush, req, pick, grant;
  ptr_t rr_ptr, ptr_nxt, win;
  logic [`REG_IDX-1:0] rd_win;
  logic rdwen_win, has_grant, rfwen_nxt;
  logic [XLEN-1:0] wdata_win;
  assign flush = {bus.fpu_flush, bus.vpu_flush, bus.muldiv_flush, bus.lsu_flush, bus.com_flush};
  assign req = bus.src_vld & ~flush;
  lieat_wbu_rr_pick u_pick (.req(req), .ptr(rr_ptr), .grant(pick));
  // No unit may see rdy while reset holds the writeback stage clear
  assign grant = reset ? '0 : pick;
  assign bus.src_rdy = grant;
  assign has_grant = |grant;
  always_comb begin
    win = '0;
    rd_win = '0;
    rdwen_win = 1'b0;
    wdata_win = '0;
    for (int i = 0; i < NSRC; i++) begin
      win = grant[i] ? ptr_t'(i) : win;
      rd_win = grant[i] ? bus.src_rd[i*`REG_IDX +: `REG_IDX] : rd_win;
      rdwen_win = grant[i] ? bus.src_rdwen[i] : rdwen_win;
      wdata_win = grant[i] ? bus.src_wdata[i*XLEN +: XLEN] : wdata_win;
    end
  end
  assign ptr_nxt = (win == ptr_t'(WB_FPU)) ? '0 : win + ptr_t'(1);
  // x0 writes still retire to clear the tracker but never touch the regfile
  assign rfwen_nxt = has_grant & rdwen_win & (|rd_win);
  lieat_general_dfflr #(PTR_W) u_ptr (
    .clk(clock), .rst(reset), .lden(has_grant), .dnxt(ptr_nxt), .qout(rr_ptr)
  );
  lieat_general_dfflr #(1) u_ena (
    .clk(clock), .rst(reset), .lden(1'b1), .dnxt(has_grant), .qout(bus.wbck_ena)
  );
  lieat_general_dfflr #(NSRC) u_op (
    .clk(clock), .rst(reset), .lden(1'b1), .dnxt(grant), .qout(bus.wbck_op)
  );
  lieat_general_dfflr #(1) u_rfwen (
    .clk(clock), .rst(reset), .lden(1'b1), .dnxt(rfwen_nxt), .qout(bus.wbck_rfwen)
  );
  lieat_general_dfflr #(`REG_IDX) u_rd (
    .clk(clock), .rst(reset), .lden(has_grant), .dnxt(rd_win), .qout(bus.wbck_rd)
  );
  lieat_general_dfflr #(XLEN) u_wdata (
    .clk(clock), .rst(reset), .lden(has_grant), .dnxt(wdata_win), .qout(bus.wbck_wdata)
  );
`ifdef LIEAT_WBU_PERF_EN
  logic [NSRC-1:0][PERF_W-1:0] stall_cnt;
  for (genvar g = 0; g < NSRC; g++) begin : g_stall
    lieat_general_dfflr #(PERF_W) u_stall (
      .clk(clock), .rst(reset),
      .lden(req[g] & ~grant[g] & ~(&stall_cnt[g])),
      .dnxt(stall_cnt[g] + PERF_W'(1)),
      .qout(stall_cnt[g])
    );
  end
  assign bus.perf_cnt = (bus.perf_sel < 3'(NSRC)) ? stall_cnt[bus.perf_sel] : '0;
`else
  logic unused_perf_sel;
  assign unused_perf_sel = ^bus.perf_sel;
  assign bus.perf_cnt = '0;
`endif
endmodule
